alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the command FIFO entries (power of two, 2..16).
REQ-002 Parameter ALU_LAT, default 1, SHALL set the cycles from ALU load to a valid ALU `out` (1..7).
REQ-003 The module SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 cmd_valid input 1: command offered.
REQ-005 cmd_ready output 1: the FIFO can accept a command.
REQ-006 cmd_op input 3: operation code; 0..6 are valid, 7 is illegal.
REQ-007 cmd_a and cmd_b inputs 8 each: operands.
REQ-008 rsp_valid output 1: a response is held.
REQ-009 rsp_ready input 1: the consumer accepts the response.
REQ-010 rsp_data output 8: ALU result.
REQ-011 rsp_err output 1: the response belongs to an illegal opcode.
REQ-012 on output 1: ALU enable.
REQ-013 in_sel output 3: ALU input select; bit2 persist, bit1 load, bit0 reset.
REQ-014 num1 and num2 outputs 8 each: ALU operands.
REQ-015 out_sel output 7: one-hot ALU operation select.
REQ-016 alu_out input 8: ALU result.
REQ-017 busy output 1: high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-018 The command FIFO SHALL push when cmd_valid and cmd_ready are both high.
REQ-019 cmd_ready SHALL equal !full.
REQ-020 The FIFO SHALL pop only in IDLE when non-empty.
REQ-021 A push and a pop in the same cycle SHALL leave the count unchanged, including at full: cmd_ready stays low at full that cycle, so no push occurs.
REQ-022 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, with count held separately so full and empty are unambiguous.
REQ-023 The FSM states SHALL be ALU_RST, IDLE, LOAD, WAIT, RESP.
REQ-024 ALU_RST SHALL last exactly 1 cycle, drive in_sel=3'b001 and on=1, then go to IDLE.
REQ-025 IDLE with a non-empty FIFO SHALL pop the head; an opcode of 0..6 goes to LOAD, opcode 7 goes directly to RESP with rsp_err=1 and rsp_data=8'h00.
REQ-026 LOAD SHALL last 1 cycle: in_sel=3'b010, num1=a, num2=b, out_sel=1<<op, on=1; then WAIT.
REQ-027 WAIT SHALL drive in_sel=3'b100 with num1, num2 and out_sel held, count ALU_LAT cycles, capture alu_out into rsp_data in the final WAIT cycle, then go to RESP.
REQ-028 RESP SHALL hold rsp_valid=1 with rsp_data and rsp_err stable until rsp_ready=1, and SHALL return to IDLE on the accept cycle.
REQ-029 An accept and a pop SHALL NOT occur in the same cycle; the next LOAD occurs no earlier than 2 cycles after the accept edge.
REQ-030 End-to-end latency for a valid op with an empty FIFO and rsp_ready=1 SHALL be ALU_LAT+3 cycles from the push edge to the rsp_valid rise.
REQ-031 In IDLE and RESP, in_sel SHALL be 3'b000, on SHALL be 1, and num1, num2 and out_sel SHALL hold their last values.
REQ-032 out_sel SHALL always be zero or one-hot; it is never driven from opcode 7.
REQ-033 cmd_valid with cmd_ready low SHALL be ignored (no drop, no overwrite).
REQ-034 rsp_ready while rsp_valid is low SHALL have no effect.

Reset
REQ-035 When rst=1 at a rising edge, the block SHALL clear the FIFO (count 0, pointers 0) and enter ALU_RST on the first cycle after rst deasserts.
REQ-036 While rst is high, outputs SHALL be: cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, on=0, in_sel=0, num1=0, num2=0, out_sel=0, busy=1.
REQ-037 A reset during LOAD, WAIT or RESP SHALL abandon the operation with no response, and queued commands SHALL be lost.
REQ-038 cmd_ready SHALL rise in ALU_RST, on the first cycle after reset.

Verification
REQ-039 Reset release scenario: release reset with no commands -> exactly one in_sel=001 cycle, then IDLE with in_sel=000, cmd_ready=1, busy=0.
REQ-040 Single-op scenario: push op=3, a=8'h57, b=8'h1A with ALU_LAT=1 and a model ALU -> LOAD shows out_sel=7'b0001000, num1=57, num2=1A; rsp_valid rises 4 cycles after the push with rsp_data equal to the model result and rsp_err=0.
REQ-041 Full-FIFO scenario: hold rsp_ready=0 and push 6 commands -> cmd_ready drops after 4 accepted while one op is in progress, no command is overwritten, and all responses arrive in order once rsp_ready=1.
REQ-042 Illegal-op scenario: push op=7 -> no LOAD cycle, out_sel unchanged, rsp_err=1, rsp_data=00.
REQ-043 Mid-op reset scenario: assert rst during WAIT with 2 commands queued -> no rsp_valid, an ALU_RST pulse after release, FIFO empty, busy=0 two cycles later.
REQ-044 Back-pressure scenario: hold rsp_ready=0 for 10 cycles in RESP -> rsp_data and rsp_err stable, in_sel=000, and no FIFO pop.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command sequencer for an external multi-cycle ALU: queues commands in a FIFO,
// steps the ALU through reset/load/persist and returns one response per command.
module alu_op_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       on,
  output logic [2:0] in_sel,
  output logic [7:0] num1,
  output logic [7:0] num2,
  output logic [6:0] out_sel,
  input  logic [7:0] alu_out,
  output logic       busy
);

  localparam int DATA_W  = 8;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 3 + 2 * DATA_W;

  typedef enum logic [2:0] {ALU_RST, IDLE, LOAD, WAIT, RESP} state_t;

  state_t             state;
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [2:0]         wait_cnt;
  logic [ENTRY_W-1:0] head;
  logic [2:0]         head_op;
  logic [DATA_W-1:0]  head_a;
  logic [DATA_W-1:0]  head_b;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !rst && !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = !rst && (state == IDLE) && !empty;

  assign head    = mem[rd_ptr];
  assign head_op = head[ENTRY_W-1 -: 3];
  assign head_a  = head[2*DATA_W-1 -: DATA_W];
  assign head_b  = head[DATA_W-1:0];

  // ---- command FIFO storage and control ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- sequencing FSM ----
  // The ALU registers its operands on the LOAD edge and presents out ALU_LAT
  // edges later, so WAIT spans ALU_LAT+1 cycles with the capture on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ALU_RST;
      wait_cnt <= '0;
      num1     <= '0;
      num2     <= '0;
      out_sel  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        ALU_RST: state <= IDLE;
        IDLE: begin
          if (!empty) begin
            if (head_op == 3'd7) begin
              rsp_err  <= 1'b1;
              rsp_data <= '0;
              state    <= RESP;
            end else begin
              num1    <= head_a;
              num2    <= head_b;
              out_sel <= 7'(7'd1 << head_op);
              rsp_err <= 1'b0;
              state   <= LOAD;
            end
          end
        end
        LOAD: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 3'(ALU_LAT)) begin
            rsp_data <= alu_out;
            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= ALU_RST;
      endcase
    end
  end

  // ---- state-decoded ALU control; everything forced quiet while rst is high ----
  always_comb begin
    in_sel = 3'b000;
    if (!rst) begin
      case (state)
        ALU_RST: in_sel = 3'b001;
        LOAD:    in_sel = 3'b010;
        WAIT:    in_sel = 3'b100;
        default: in_sel = 3'b000;
      endcase
    end
  end

  assign on        = !rst;
  assign rsp_valid = !rst && (state == RESP);
  assign busy      = rst || (state != IDLE) || !empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a behavioural ALU answers the
// sequencer, a queue model predicts responses and ALU loads in order.
module tb_alu_op_sequencer;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       on;
  logic [2:0] in_sel;
  logic [7:0] num1;
  logic [7:0] num2;
  logic [6:0] out_sel;
  logic [7:0] alu_out;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_rsp[$];
  cmd_t       exp_load[$];

  always #5 clk = ~clk;

  alu_op_sequencer #(.FIFO_DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .on(on), .in_sel(in_sel), .num1(num1), .num2(num2),
    .out_sel(out_sel), .alu_out(alu_out), .busy(busy)
  );

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return {a[6:0], a[7]};
      3'd6:    return (a > b) ? a : b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] onehot_to_op(input logic [6:0] s);
    logic [2:0] r = 3'd7;
    for (int k = 0; k < 7; k++) if (s[k]) r = 3'(k);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural ALU: latches operands on load, result appears LAT edges later.
  logic [7:0] ra, rb;
  logic [2:0] rop;
  int         cd = 0;
  logic [7:0] alu_q = 8'h00;
  assign alu_out = alu_q;

  always @(posedge clk) begin
    if (in_sel == 3'b001) begin
      cd    <= 0;
      alu_q <= 8'h00;
    end else if (in_sel == 3'b010) begin
      ra    <= num1;
      rb    <= num2;
      rop   <= onehot_to_op(out_sel);
      cd    <= LAT;
      alu_q <= 8'($urandom);
    end else if (cd > 1) begin
      cd    <= cd - 1;
      alu_q <= 8'($urandom);
    end else if (cd == 1) begin
      cd    <= 0;
      alu_q <= alu_f(rop, ra, rb);
    end
  end

  // Monitor: predicts on push, checks loads and responses as they appear.
  logic       stall = 1'b0;
  logic [8:0] prev_rsp = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_rsp.delete();
      exp_load.delete();
      stall = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        if (cmd_op == 3'd7) begin
          exp_rsp.push_back({1'b1, 8'h00});
        end else begin
          exp_rsp.push_back({1'b0, alu_f(cmd_op, cmd_a, cmd_b)});
          exp_load.push_back('{op: cmd_op, a: cmd_a, b: cmd_b});
        end
      end
      if (in_sel == 3'b010) begin
        if (exp_load.size() == 0) begin
          chk("unexpected_load", 32'(in_sel), 32'd0);
        end else begin
          cmd_t e;
          e = exp_load.pop_front();
          chk("load_num1", 32'(num1), 32'(e.a));
          chk("load_num2", 32'(num2), 32'(e.b));
          chk("load_out_sel", 32'(out_sel), 32'(7'(7'd1 << e.op)));
        end
      end
      if (stall && rsp_valid)
        chk("rsp_hold", 32'({rsp_err, rsp_data}), 32'(prev_rsp));
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          logic [8:0] r;
          r = exp_rsp.pop_front();
          chk("rsp_err_data", 32'({rsp_err, rsp_data}), 32'(r));
        end
      end
      stall    = rsp_valid && !rsp_ready;
      prev_rsp = {rsp_err, rsp_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!busy && exp_rsp.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic push1(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int   n;
    bit   saw_load;
    int   idx;
    bit   acc;
    int   bad;
    logic [6:0] prev_sel;
    cmd_t burst[6];

    // Reset values
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'd0);
    chk("rst_alu_ctl", 32'({on, in_sel, out_sel}), 32'd0);
    chk("rst_nums", 32'({num1, num2}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // Release: one ALU_RST cycle, then IDLE
    rst = 1'b0;
    #1;
    chk("alu_rst_in_sel", 32'(in_sel), 32'd1);
    chk("alu_rst_on", 32'(on), 32'd1);
    chk("alu_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("idle_in_sel", 32'(in_sel), 32'd0);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single op: OR of 57 and 1A
    push1(3'd3, 8'h57, 8'h1A);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      n++;
      if (in_sel == 3'b010) begin
        chk("single_out_sel", 32'(out_sel), 32'h08);
        chk("single_nums", 32'({num1, num2}), 32'h571A);
      end
      if (rsp_valid) break;
    end
    chk("single_latency", 32'(n), 32'(LAT + 3));
    chk("single_data", 32'({rsp_err, rsp_data}), 32'h05F);
    wait_idle();

    // Illegal op goes straight to an error response
    prev_sel = out_sel;
    push1(3'd7, 8'hAA, 8'h55);
    saw_load = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (in_sel == 3'b010) saw_load = 1'b1;
      if (rsp_valid) break;
      tick();
    end
    chk("illegal_no_load", 32'(saw_load), 32'd0);
    chk("illegal_out_sel", 32'(out_sel), 32'(prev_sel));
    chk("illegal_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'h300);
    wait_idle();

    // Full FIFO with response back-pressure
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      burst[i].op = (i == 2) ? 3'd7 : 3'(i % 7);
      burst[i].a  = 8'($urandom);
      burst[i].b  = 8'($urandom);
    end
    idx = 0;
    for (int c = 0; c < 15; c++) begin
      cmd_op = burst[idx].op;
      cmd_a = burst[idx].a;
      cmd_b = burst[idx].b;
      cmd_valid = 1'b1;
      acc = cmd_ready;
      tick();
      if (acc) idx++;
      if (idx == 6) break;
    end
    chk("full_accepted", 32'(idx), 32'(DEPTH + 1));
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (!rsp_valid || in_sel != 3'b000 || cmd_ready) bad++;
      tick();
    end
    chk("backpressure_hold", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 60 && idx < 6; c++) begin
      acc = cmd_ready;
      tick();
      if (acc) idx++;
    end
    cmd_valid = 1'b0;
    chk("full_last_accepted", 32'(idx), 32'd6);
    wait_idle();

    // Randomized traffic with random back-pressure
    for (int c = 0; c < 500; c++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 3'($urandom);
      cmd_a = 8'($urandom);
      cmd_b = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();

    // Reset during WAIT with two commands queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) push1(3'(i), 8'($urandom), 8'($urandom));
    chk("midrst_in_wait", 32'(in_sel), 32'h4);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_alu_rst", 32'({rsp_valid, in_sel}), 32'd1);
    tick();
    chk("midrst_busy1", 32'(busy), 32'd0);
    tick();
    chk("midrst_busy2", 32'(busy), 32'd0);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid || in_sel != 3'b000 || !cmd_ready) bad++;
      tick();
    end
    chk("midrst_flushed", 32'(bad), 32'd0);
    rsp_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
